store_buffer_ctrl: RTL and testbench

- In-order store buffer between execute_lsu and the data bus.
- Accepts speculative stores from execute_lsu and marks them committed when commit reports the store's ROB id.
- Drains committed stores to the bus, one at a time, through a req/ack handshake.
- On a commit flush, discards every store that is still uncommitted.

---
 rtl/store_buffer_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_store_buffer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: in-order store buffer between execute_lsu and the data bus.
// Stores enter speculatively and are marked committed by ROB id. Committed
// stores drain from the head, one bus write at a time. A flush drops every
// entry behind the first uncommitted one.

package store_buffer_ctrl_pkg;
  localparam int SB_ROB_ID_WIDTH = 7;

  typedef struct packed {
    logic                       enable;
    logic                       flush;
    logic                       committed_rob_id_valid;
    logic [SB_ROB_ID_WIDTH-1:0] committed_rob_id;
  } commit_feedback_pack_t;
endpackage

module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int ROB_ID_WIDTH = SB_ROB_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROB_ID_WIDTH-1:0] exlsu_stbuf_rob_id,
  input  logic [ADDR_WIDTH-1:0]   exlsu_stbuf_write_addr,
  input  logic [SIZE_WIDTH-1:0]   exlsu_stbuf_write_size,
  input  logic [DATA_WIDTH-1:0]   exlsu_stbuf_write_data,
  input  logic                    exlsu_stbuf_push,
  output logic                    stbuf_exlsu_full,
  input  commit_feedback_pack_t   commit_feedback_pack,
  output logic                    stbuf_bus_write_req,
  output logic [ADDR_WIDTH-1:0]   stbuf_bus_addr,
  output logic [SIZE_WIDTH-1:0]   stbuf_bus_size,
  output logic [DATA_WIDTH-1:0]   stbuf_bus_data,
  input  logic                    bus_stbuf_write_ack,
  output logic                    stbuf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  // Entry storage: payload arrays carry no reset, validity comes from head/count.
  logic [ROB_ID_WIDTH-1:0] r_rob_id [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_addr   [DEPTH];
  logic [SIZE_WIDTH-1:0]   r_size   [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data   [DEPTH];
  logic [DEPTH-1:0]        r_cmt;

  logic [PTR_W-1:0]        r_head, r_tail;
  logic [CNT_W-1:0]        r_count;
  state_t                  r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0]   r_bus_addr;
  logic [SIZE_WIDTH-1:0]   r_bus_size;
  logic [DATA_WIDTH-1:0]   r_bus_data;

  logic                    w_full, w_empty;
  logic                    w_flush, w_cm_en;
  logic [ROB_ID_WIDTH-1:0] w_cm_id;
  logic                    w_push, w_pop, w_launch;
  logic [DEPTH-1:0]        w_valid, w_cmt_nxt;
  logic [CNT_W-1:0]        w_ccount;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_flush = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign w_cm_en = commit_feedback_pack.enable & commit_feedback_pack.committed_rob_id_valid;
  assign w_cm_id = ROB_ID_WIDTH'(commit_feedback_pack.committed_rob_id);

  // A push is taken only with room (pre-edge count) and no flush this cycle.
  assign w_push = exlsu_stbuf_push & ~w_full & ~w_flush;
  assign w_pop  = (r_state == S_WRITE) & bus_stbuf_write_ack;

  // Per-entry validity and committed bits after this cycle's commit marking.
  always_comb begin
    w_valid   = '0;
    w_cmt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i]   = ({1'b0, PTR_W'(PTR_W'(i) - r_head)} < r_count);
      w_cmt_nxt[i] = w_valid[i] &
                     (r_cmt[i] | (w_cm_en & (r_rob_id[i] == w_cm_id)));
    end
  end

  // Run length of committed entries starting at head; this is what a flush keeps.
  always_comb begin
    logic             run;
    logic [PTR_W-1:0] idx;
    w_ccount = '0;
    run      = 1'b1;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if (run && w_cmt_nxt[idx]) w_ccount = w_ccount + CNT_W'(1);
      else                       run = 1'b0;
    end
  end

  // Pointer, count and committed-bit bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_cmt   <= '0;
    end else begin
      r_cmt <= w_cmt_nxt;
      if (w_pop) begin
        r_cmt[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push) r_cmt[r_tail] <= 1'b0;
      if (w_flush) begin
        // Tail is re-anchored on the pre-pop head; a same-cycle pop still removes one.
        r_tail  <= r_head + w_ccount[PTR_W-1:0];
        r_count <= w_ccount - CNT_W'(w_pop);
      end else begin
        r_tail  <= r_tail + PTR_W'(w_push);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Payload write at tail on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rob_id[r_tail] <= exlsu_stbuf_rob_id;
      r_addr[r_tail]   <= exlsu_stbuf_write_addr;
      r_size[r_tail]   <= exlsu_stbuf_write_size;
      r_data[r_tail]   <= exlsu_stbuf_write_data;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Drain FSM next state: launch from registered head commit, hold until ack.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && r_cmt[r_head]) begin
          w_launch    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus_stbuf_write_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus fields are captured at launch and held stable through the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bus_addr <= '0;
      r_bus_size <= '0;
      r_bus_data <= '0;
    end else if (w_launch) begin
      r_bus_addr <= r_addr[r_head];
      r_bus_size <= r_size[r_head];
      r_bus_data <= r_data[r_head];
    end
  end

  assign stbuf_bus_write_req = (r_state == S_WRITE);
  assign stbuf_bus_addr      = r_bus_addr;
  assign stbuf_bus_size      = r_bus_size;
  assign stbuf_bus_data      = r_bus_data;
  assign stbuf_exlsu_full    = w_full;
  assign stbuf_empty         = w_empty;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: push/commit/drain, full, flush, reset.
module tb_store_buffer_ctrl;
  import store_buffer_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  rob_id;
  logic [31:0] waddr, wdata;
  logic [2:0]  wsize;
  logic        push;
  logic        full;
  commit_feedback_pack_t cf;
  logic        req;
  logic [31:0] baddr, bdata;
  logic [2:0]  bsize;
  logic        ack;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .exlsu_stbuf_rob_id     (rob_id),
    .exlsu_stbuf_write_addr (waddr),
    .exlsu_stbuf_write_size (wsize),
    .exlsu_stbuf_write_data (wdata),
    .exlsu_stbuf_push       (push),
    .stbuf_exlsu_full       (full),
    .commit_feedback_pack   (cf),
    .stbuf_bus_write_req    (req),
    .stbuf_bus_addr         (baddr),
    .stbuf_bus_size         (bsize),
    .stbuf_bus_data         (bdata),
    .bus_stbuf_write_ack    (ack),
    .stbuf_empty            (empty)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [6:0] id, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
    rob_id = id; waddr = a; wsize = s; wdata = d; push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic do_commit(input logic [6:0] id);
    cf = '{enable: 1'b1, flush: 1'b0, committed_rob_id_valid: 1'b1, committed_rob_id: id};
    tick();
    cf = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Bounded wait for req; ok=0 when the budget runs out.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", req); end
    n_tests++; if (baddr !== 32'h0 || bsize !== 3'h0 || bdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got %h/%h/%h want 0", baddr, bsize, bdata); end
    n_tests++; if (full !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_flags got full=%b empty=%b want 0/1", full, empty); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_uncommitted_hold();
    bit hold_ok = 1'b1;
    do_push(7'd7, 32'haaccbeef, 3'd2, 32'h0000beef);
    n_tests++; if (empty !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL push1_flags got empty=%b full=%b want 0/0", empty, full); end
    for (int i = 0; i < 5; i++) begin
      if (req !== 1'b0) hold_ok = 1'b0;
      tick();
    end
    n_tests++; if (!hold_ok) begin n_fail++; $display("FAIL uncommitted_req got 1 want 0"); end
  endtask

  task automatic test_commit_drain();
    bit stable = 1'b1;
    do_commit(7'd7);
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL commit_lat0 got %b want 0", req); end
    tick();
    n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL commit_lat1 got %b want 1", req); end
    n_tests++; if (baddr !== 32'haaccbeef || bsize !== 3'd2 || bdata !== 32'h0000beef) begin
      n_fail++; $display("FAIL drain_fields got %h/%h/%h want aaccbeef/2/0000beef", baddr, bsize, bdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req !== 1'b1 || baddr !== 32'haaccbeef || bsize !== 3'd2 || bdata !== 32'h0000beef)
        stable = 1'b0;
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL hold_stable got unstable want stable"); end
    do_ack();
    n_tests++; if (req !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL after_ack got req=%b empty=%b want 0/1", req, empty); end
  endtask

  task automatic test_full_wrap();
    bit ok;
    for (int i = 0; i < 8; i++)
      do_push(7'(i), 32'h1000 + 32'(i) * 4, 3'd4, 32'(i) * 32'h11);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after8 got %b want 1", full); end
    do_push(7'd8, 32'h2000, 3'd4, 32'hdead);
    n_tests++; if (full !== 1'b1 || empty !== 1'b0) begin
      n_fail++; $display("FAIL push9_dropped got full=%b empty=%b want 1/0", full, empty); end
    do_commit(7'd0);
    wait_req(ok);
    n_tests++; if (!ok || baddr !== 32'h1000) begin
      n_fail++; $display("FAIL drain_rob0 got req=%b addr=%h want 1/00001000", req, baddr); end
    do_ack();
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_after_ack got %b want 0", full); end
    tick(); tick();
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL rob1_uncommitted got %b want 0", req); end
    do_commit(7'd1);
    wait_req(ok);
    n_tests++; if (!ok || baddr !== 32'h1004 || bdata !== 32'h11) begin
      n_fail++; $display("FAIL drain_rob1 got addr=%h data=%h want 00001004/00000011", baddr, bdata); end
    do_ack();
    // Discard the remaining uncommitted entries 2..7.
    cf = '{enable: 1'b1, flush: 1'b1, committed_rob_id_valid: 1'b0, committed_rob_id: 7'd0};
    tick();
    cf = '0;
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL flush_all got empty=%b full=%b want 1/0", empty, full); end
  endtask

  task automatic test_flush_partial();
    bit ok;
    bit quiet = 1'b1;
    do_push(7'd1, 32'h3001, 3'd1, 32'h01);
    do_push(7'd2, 32'h3002, 3'd2, 32'h02);
    do_push(7'd3, 32'h3003, 3'd4, 32'h03);
    do_commit(7'd1);
    do_commit(7'd2);
    cf = '{enable: 1'b1, flush: 1'b1, committed_rob_id_valid: 1'b0, committed_rob_id: 7'd0};
    tick();
    cf = '0;
    wait_req(ok);
    n_tests++; if (!ok || baddr !== 32'h3001 || bsize !== 3'd1) begin
      n_fail++; $display("FAIL flush_keep1 got addr=%h size=%h want 00003001/1", baddr, bsize); end
    do_ack();
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL flush_count2 got empty=%b want 0", empty); end
    wait_req(ok);
    n_tests++; if (!ok || baddr !== 32'h3002 || bsize !== 3'd2) begin
      n_fail++; $display("FAIL flush_keep2 got addr=%h size=%h want 00003002/2", baddr, bsize); end
    do_ack();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_drop3 got empty=%b want 1", empty); end
    for (int i = 0; i < 5; i++) begin
      if (req !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL flush_no_write3 got req=1 want 0"); end
  endtask

  task automatic test_flush_push_commit();
    bit ok;
    do_push(7'd10, 32'h4000, 3'd4, 32'hcafe);
    rob_id = 7'd9; waddr = 32'h4444; wsize = 3'd4; wdata = 32'h9999; push = 1'b1;
    cf = '{enable: 1'b1, flush: 1'b1, committed_rob_id_valid: 1'b1, committed_rob_id: 7'd10};
    tick();
    push = 1'b0;
    cf = '0;
    wait_req(ok);
    n_tests++; if (!ok || baddr !== 32'h4000 || bdata !== 32'hcafe) begin
      n_fail++; $display("FAIL flush_head_survives got addr=%h data=%h want 00004000/0000cafe", baddr, bdata); end
    do_ack();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_push_dropped got empty=%b want 1", empty); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit quiet = 1'b1;
    do_push(7'd20, 32'h5000, 3'd4, 32'h5555);
    do_commit(7'd20);
    wait_req(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_pre_req got 0 want 1"); end
    rst = 1'b0;
    tick();
    n_tests++; if (req !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_write got req=%b empty=%b full=%b want 0/1/0", req, empty, full); end
    n_tests++; if (baddr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_addr got %h want 0", baddr); end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req !== 1'b0) quiet = 1'b0;
    end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL rst_no_write got req=1 want 0"); end
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; ack = 1'b0; cf = '0;
    rob_id = '0; waddr = '0; wsize = '0; wdata = '0;
    test_reset();
    test_uncommitted_hold();
    test_commit_drain();
    test_full_wrap();
    test_flush_partial();
    test_flush_push_commit();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
